// File: rtl/life_board_server.sv
// life_board_server: NxN Game of Life board memory with shadow-bank stepping (option macro: STILL_DETECT_EN)
module life_board_server #(
  parameter int N = 8,
  parameter bit WRAP = 1'b1,
  localparam int AW = $clog2(N)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] rd_addr,
  output logic [N-1:0]  rd_data,
  input  logic          load_en,
  input  logic [AW-1:0] load_addr,
  input  logic [N-1:0]  load_row,
  input  logic          step,
  output logic          busy,
  output logic          done,
  output logic [15:0]   gen_count,
  output logic          still
);
  typedef enum logic [1:0] {IDLE, COMPUTE, COMMIT} state_t;
  state_t state;
  logic [N-1:0][N-1:0] cur, nxt;
  logic [AW-1:0] r;
  logic [N-1:0] up, mid, dn, nrow;
  logic [7:0] nb;
  logic [3:0] n;

  // Column neighbour lookup: wraps around the torus or reads dead cells off the edge
  function automatic logic pick(input logic [N-1:0] v, input int c);
    if (c < 0) return WRAP ? v[N-1] : 1'b0;
    if (c >= N) return WRAP ? v[0] : 1'b0;
    return v[c[AW-1:0]];
  endfunction

  // Next-generation value of row r from rows r-1, r, r+1 of the current board
  always_comb begin
    up = (r == '0) ? (WRAP ? cur[N-1] : '0) : cur[r - 1'b1];
    mid = cur[r];
    dn = (r == AW'(N - 1)) ? (WRAP ? cur[0] : '0) : cur[r + 1'b1];
    nrow = '0;
    nb = '0;
    n = '0;
    for (int c = 0; c < N; c++) begin
      nb = {pick(up, c - 1), pick(up, c), pick(up, c + 1), pick(mid, c - 1),
            pick(mid, c + 1), pick(dn, c - 1), pick(dn, c), pick(dn, c + 1)};
      n = '0;
      for (int k = 0; k < 8; k++) n = n + {3'b000, nb[k]};
      nrow[c] = (mid[c] & ((n == 4'd2) | (n == 4'd3))) | (~mid[c] & (n == 4'd3));
    end
  end

  // Read port, load port and the IDLE -> COMPUTE -> COMMIT generation sequencer
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      cur <= '0;
      nxt <= '0;
      rd_data <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      gen_count <= '0;
      r <= '0;
      state <= IDLE;
    end else begin
      rd_data <= cur[rd_addr];
      done <= 1'b0;
      case (state)
        IDLE:
          if (step) begin
            r <= '0;
            busy <= 1'b1;
            state <= COMPUTE;
          end else if (load_en) cur[load_addr] <= load_row;
        COMPUTE: begin
          nxt[r] <= nrow;
          r <= r + 1'b1;
          state <= (r == AW'(N - 1)) ? COMMIT : COMPUTE;
        end
        COMMIT: begin
          cur <= nxt;
          gen_count <= gen_count + 16'd1;
          done <= 1'b1;
          busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end

`ifdef STILL_DETECT_EN
  // Still-life flag: set at commit when the new board equals the old one, cleared by any accepted load
  always_ff @(posedge clk or negedge reset)
    if (!reset) still <= 1'b0;
    else if (state == COMMIT) still <= (nxt == cur);
    else if (state == IDLE && !step && load_en) still <= 1'b0;
`else
  assign still = 1'b0;
`endif
endmodule

// File: tb/tb_life_board_server.sv
// tb_life_board_server: directed checks of the Life board server, toroidal and bounded instances side by side
module tb_life_board_server;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [2:0] rd_addr = '0, load_addr = '0;
  logic [7:0] load_row = '0;
  logic load_en = 1'b0, step = 1'b0;
  logic [7:0] rd_data, rd_data_nw;
  logic busy, done, still, busy_nw, done_nw, still_nw;
  logic [15:0] gen_count, gen_count_nw;
  logic [7:0][7:0] e, enw;
  logic exp_still;
  int checks = 0, errors = 0;
  int seen;

  life_board_server #(.N(8), .WRAP(1'b1)) dut (
    .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data),
    .load_en(load_en), .load_addr(load_addr), .load_row(load_row), .step(step),
    .busy(busy), .done(done), .gen_count(gen_count), .still(still)
  );

  life_board_server #(.N(8), .WRAP(1'b0)) dut_nw (
    .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data_nw),
    .load_en(load_en), .load_addr(load_addr), .load_row(load_row), .step(step),
    .busy(busy_nw), .done(done_nw), .gen_count(gen_count_nw), .still(still_nw)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [2:0] a, input logic [7:0] v);
    load_addr = a;
    load_row = v;
    load_en = 1'b1;
    tick();
    load_en = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #2;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_rd_data", rd_data, 8'h00);
    chk("rst_gen", gen_count, 16'd0);
    chk("rst_still", still, 1'b0);
    reset = 1'b1;
    tick();
  endtask

  task automatic do_step(input string tag);
    int lat;
    step = 1'b1;
    tick();
    step = 1'b0;
    chk({tag, "_busy"}, busy, 1'b1);
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (done === 1'b1) begin
        lat = i;
        break;
      end
    end
    chk({tag, "_done_latency"}, lat, 9);
    chk({tag, "_busy_after"}, busy, 1'b0);
  endtask

  task automatic check_board(input string tag, input logic [7:0][7:0] x, input logic [7:0][7:0] xnw,
                             input bit use_nw);
    for (int i = 0; i < 8; i++) begin
      rd_addr = 3'(i);
      tick();
      chk($sformatf("%s_row%0d", tag, i), rd_data, x[i]);
      if (use_nw) chk($sformatf("%s_nw_row%0d", tag, i), rd_data_nw, xnw[i]);
    end
  endtask

  initial begin
`ifdef STILL_DETECT_EN
    exp_still = 1'b1;
`else
    exp_still = 1'b0;
`endif
    // reset state and empty board
    tick();
    do_reset();
    e = '0;
    check_board("reset", e, e, 1'b1);
    chk("reset_busy_idle", busy, 1'b0);

    // blinker plus read-before-write on the loaded row
    rd_addr = 3'd3;
    load(3'd3, 8'b00011100);
    chk("rbw_old", rd_data, 8'h00);
    tick();
    chk("rbw_new", rd_data, 8'b00011100);
    do_step("blink1");
    tick();
    chk("done_pulse_low", done, 1'b0);
    chk("blink1_gen", gen_count, 16'd1);
    e = '0;
    e[2] = 8'b00001000;
    e[3] = 8'b00001000;
    e[4] = 8'b00001000;
    check_board("blink1", e, e, 1'b1);
    chk("blink1_still", still, 1'b0);
    do_step("blink2");
    e = '0;
    e[3] = 8'b00011100;
    check_board("blink2", e, e, 1'b1);
    chk("blink2_gen", gen_count, 16'd2);

    // block still life
    do_reset();
    load(3'd3, 8'b00011000);
    load(3'd4, 8'b00011000);
    do_step("block");
    e = '0;
    e[3] = 8'b00011000;
    e[4] = 8'b00011000;
    check_board("block", e, e, 1'b1);
    chk("block_gen", gen_count, 16'd1);
    chk("block_still", still, exp_still);
    load(3'd0, 8'h00);
    chk("still_cleared_by_load", still, 1'b0);

    // 3x3 square: centre has 8 live neighbours
    do_reset();
    load(3'd2, 8'h1C);
    load(3'd3, 8'h1C);
    load(3'd4, 8'h1C);
    do_step("sq");
    e = '0;
    e[1] = 8'h08;
    e[2] = 8'h14;
    e[3] = 8'h22;
    e[4] = 8'h14;
    e[5] = 8'h08;
    check_board("sq", e, e, 1'b1);

    // edge blinkers: wrap vs bounded
    do_reset();
    load(3'd0, 8'h07);
    load(3'd3, 8'h01);
    load(3'd4, 8'h01);
    load(3'd5, 8'h01);
    do_step("edge");
    e = '0;
    e[7] = 8'h02;
    e[0] = 8'h02;
    e[1] = 8'h02;
    e[4] = 8'h83;
    enw = '0;
    enw[0] = 8'h02;
    enw[1] = 8'h02;
    enw[4] = 8'h03;
    check_board("edge", e, enw, 1'b1);

    // glider travels once around the torus in 32 generations
    do_reset();
    load(3'd0, 8'b00000010);
    load(3'd1, 8'b00000100);
    load(3'd2, 8'b00000111);
    for (int g = 0; g < 32; g++) do_step($sformatf("glider%0d", g));
    e = '0;
    e[0] = 8'b00000010;
    e[1] = 8'b00000100;
    e[2] = 8'b00000111;
    check_board("glider", e, e, 1'b0);
    chk("glider_gen", gen_count, 16'd32);

    // step and load while busy are ignored; reads stay on the old board
    do_reset();
    load(3'd3, 8'h1C);
    step = 1'b1;
    tick();
    step = 1'b0;
    tick();
    tick();
    step = 1'b1;
    load_en = 1'b1;
    load_addr = 3'd0;
    load_row = 8'hFF;
    rd_addr = 3'd3;
    tick();
    chk("busy_read_old", rd_data, 8'h1C);
    chk("busy_mid", busy, 1'b1);
    tick();
    step = 1'b0;
    load_en = 1'b0;
    chk("busy_read_old2", rd_data, 8'h1C);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (done === 1'b1) begin
        seen = 1;
        break;
      end
    end
    chk("ignore_done_seen", seen, 1);
    for (int i = 0; i < 12; i++) tick();
    chk("ignore_gen", gen_count, 16'd1);
    e = '0;
    e[2] = 8'h08;
    e[3] = 8'h08;
    e[4] = 8'h08;
    check_board("ignore", e, e, 1'b1);

    // reset in the middle of COMPUTE aborts cleanly
    do_reset();
    load(3'd3, 8'h1C);
    step = 1'b1;
    tick();
    step = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    reset = 1'b0;
    #1;
    chk("abort_busy", busy, 1'b0);
    chk("abort_done", done, 1'b0);
    chk("abort_rd", rd_data, 8'h00);
    chk("abort_gen", gen_count, 16'd0);
    #2;
    reset = 1'b1;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done === 1'b1) seen++;
    end
    chk("abort_no_done", seen, 0);
    e = '0;
    check_board("abort", e, e, 1'b1);
    load(3'd3, 8'h1C);
    do_step("after_abort");
    e[2] = 8'h08;
    e[3] = 8'h08;
    e[4] = 8'h08;
    check_board("after_abort", e, e, 1'b1);
    chk("after_abort_gen", gen_count, 16'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
